// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues one instruction-memory read at a time and
// presents the returned word to decode through a single-entry output buffer.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  input  logic        dec_ready,
  output logic        if_valid,
  output logic [31:0] instruction,
  output logic [31:0] pc_if,
  output logic [31:0] pc_plus_4_if
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_FULL  = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_if_q, pc_if_d;
  logic [31:0] pc_plus_4_if_q, pc_plus_4_if_d;

  logic [31:0] target_aligned;
  logic [31:0] pc_plus_4;

  assign target_aligned = {redirect_target[31:2], 2'b00};
  assign pc_plus_4      = pc_q + 32'd4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_REQ;
      pc_q           <= RESET_PC;
      if_valid_q     <= 1'b0;
      instr_q        <= NOP_INSTR;
      pc_if_q        <= RESET_PC;
      pc_plus_4_if_q <= RESET_PC + 32'd4;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      if_valid_q     <= if_valid_d;
      instr_q        <= instr_d;
      pc_if_q        <= pc_if_d;
      pc_plus_4_if_q <= pc_plus_4_if_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    if_valid_d     = if_valid_q;
    instr_d        = instr_q;
    pc_if_d        = pc_if_q;
    pc_plus_4_if_d = pc_plus_4_if_q;
    imem_req       = 1'b0;

    unique case (state_q)
      S_REQ: begin
        if (redirect) begin
          pc_d = target_aligned;
        end else begin
          imem_req = 1'b1;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          pc_d    = target_aligned;
          state_d = imem_rvalid ? S_REQ : S_FLUSH;
        end else if (imem_rvalid) begin
          instr_d        = imem_rdata;
          pc_if_d        = pc_q;
          pc_plus_4_if_d = pc_plus_4;
          if_valid_d     = 1'b1;
          pc_d           = pc_plus_4;
          state_d        = S_FULL;
        end
      end
      S_FULL: begin
        // Redirect beats dec_ready: the presented instruction is on the wrong path.
        if (redirect) begin
          if_valid_d = 1'b0;
          instr_d    = NOP_INSTR;
          pc_d       = target_aligned;
          state_d    = S_REQ;
        end else if (dec_ready) begin
          if_valid_d = 1'b0;
          instr_d    = NOP_INSTR;
          imem_req   = 1'b1;
          state_d    = S_WAIT;
        end
      end
      S_FLUSH: begin
        if (redirect) begin
          pc_d = target_aligned;
        end
        if (imem_rvalid) begin
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase

    // The reset value of the FSM would otherwise request while reset is held.
    if (!rst_n) begin
      imem_req = 1'b0;
    end
  end

  assign imem_addr    = pc_q;
  assign if_valid     = if_valid_q;
  assign instruction  = instr_q;
  assign pc_if        = pc_if_q;
  assign pc_plus_4_if = pc_plus_4_if_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: scripted memory responses, redirects and
// decode back-pressure, with hand-computed expected outputs.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] IA  = 32'hAAAA_0001;
  localparam logic [31:0] IB  = 32'hBBBB_0002;
  localparam logic [31:0] IC  = 32'hCCCC_0003;
  localparam logic [31:0] ID  = 32'hDDDD_0004;
  localparam logic [31:0] IE  = 32'hEEEE_0005;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        dec_ready;
  logic        if_valid;
  logic [31:0] instruction;
  logic [31:0] pc_if;
  logic [31:0] pc_plus_4_if;

  int checks = 0;
  int errors = 0;

  fetch_stage dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .dec_ready       (dec_ready),
    .if_valid        (if_valid),
    .instruction     (instruction),
    .pc_if           (pc_if),
    .pc_plus_4_if    (pc_plus_4_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] ins,
                         input logic [31:0] pc, input logic [31:0] pc4);
    chk({tag, ".if_valid"}, {31'd0, if_valid}, {31'd0, v});
    chk({tag, ".instruction"}, instruction, ins);
    chk({tag, ".pc_if"}, pc_if, pc);
    chk({tag, ".pc_plus_4_if"}, pc_plus_4_if, pc4);
  endtask

  task automatic chk_req(input string tag, input logic r, input logic [31:0] addr);
    chk({tag, ".imem_req"}, {31'd0, imem_req}, {31'd0, r});
    if (r) chk({tag, ".imem_addr"}, imem_addr, addr);
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    imem_rvalid = 1'b0; imem_rdata = 32'd0;
    redirect = 1'b0; redirect_target = 32'd0; dec_ready = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk_out("reset", 1'b0, NOP, 32'h0, 32'h4);
    chk_req("reset", 1'b0, 32'h0);
    $display("step reset: if_valid=%0b instr=%h req=%0b", if_valid, instruction, imem_req);

    cyc(); rst_n = 1'b1; #1;
    chk_req("first_req", 1'b1, 32'h0);
    $display("step release: req=%0b addr=%h", imem_req, imem_addr);

    // Latency 1, decode always ready: fetch A then B.
    cyc(); imem_rvalid = 1'b1; imem_rdata = IA; dec_ready = 1'b1; #1;
    chk_req("wait_a", 1'b0, 32'h0);
    cyc(); imem_rvalid = 1'b0; #1;
    chk_out("full_a", 1'b1, IA, 32'h0, 32'h4);
    chk_req("full_a", 1'b1, 32'h4);
    $display("step A: instr=%h pc_if=%h next addr=%h", instruction, pc_if, imem_addr);
    cyc(); imem_rvalid = 1'b1; imem_rdata = IB; #1;
    chk({"wait_b", ".if_valid"}, {31'd0, if_valid}, 32'd0);
    chk({"wait_b", ".instruction"}, instruction, NOP);
    chk_req("wait_b", 1'b0, 32'h0);

    // FULL at pc_if 0x4: redirect wins over dec_ready, target low bits dropped.
    cyc(); imem_rvalid = 1'b0; redirect = 1'b1; redirect_target = 32'h203; #1;
    chk_out("full_b", 1'b1, IB, 32'h4, 32'h8);
    chk_req("full_b_redir", 1'b0, 32'h0);
    $display("step B: instr=%h pc_if=%h redirect to 203", instruction, pc_if);
    cyc(); redirect = 1'b0; dec_ready = 1'b0; #1;
    chk({"after_redir", ".if_valid"}, {31'd0, if_valid}, 32'd0);
    chk({"after_redir", ".instruction"}, instruction, NOP);
    chk_req("after_redir", 1'b1, 32'h200);
    $display("step redirect: req addr=%h", imem_addr);

    // Latency 3, then decode stalls for 5 cycles.
    cyc(); #1; chk_req("lat3_w1", 1'b0, 32'h0);
    cyc(); #1; chk_req("lat3_w2", 1'b0, 32'h0);
    cyc(); imem_rvalid = 1'b1; imem_rdata = IC; #1;
    chk({"lat3_w3", ".if_valid"}, {31'd0, if_valid}, 32'd0);
    cyc(); imem_rvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      // A spurious response while FULL must be ignored.
      imem_rvalid = (i == 2);
      imem_rdata  = 32'hDEAD_BEEF;
      #1;
      chk_out($sformatf("hold%0d", i), 1'b1, IC, 32'h200, 32'h204);
      chk_req($sformatf("hold%0d", i), 1'b0, 32'h0);
      $display("step hold %0d: instr=%h pc_if=%h req=%0b", i, instruction, pc_if, imem_req);
      cyc();
    end
    imem_rvalid = 1'b0; dec_ready = 1'b1; #1;
    chk_out("release", 1'b1, IC, 32'h200, 32'h204);
    chk_req("release", 1'b1, 32'h204);

    // Redirect while waiting: stale response goes through FLUSH and is dropped.
    cyc(); dec_ready = 1'b0; redirect = 1'b1; redirect_target = 32'h100; #1;
    chk({"wait_redir", ".if_valid"}, {31'd0, if_valid}, 32'd0);
    chk_req("wait_redir", 1'b0, 32'h0);
    cyc(); redirect = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0BAD_0BAD; #1;
    chk({"flush", ".if_valid"}, {31'd0, if_valid}, 32'd0);
    chk_req("flush", 1'b0, 32'h0);
    cyc(); imem_rvalid = 1'b0; #1;
    chk({"post_flush", ".if_valid"}, {31'd0, if_valid}, 32'd0);
    chk({"post_flush", ".instruction"}, instruction, NOP);
    chk_req("post_flush", 1'b1, 32'h100);
    $display("step flush: if_valid=%0b req addr=%h", if_valid, imem_addr);

    // Redirect in REQ to the top word, then wrap-around.
    redirect = 1'b1; redirect_target = 32'hFFFF_FFFF; #1;
    chk_req("req_redir", 1'b0, 32'h0);
    cyc(); redirect = 1'b0; #1;
    chk_req("top_req", 1'b1, 32'hFFFF_FFFC);
    cyc(); imem_rvalid = 1'b1; imem_rdata = ID; #1;
    cyc(); imem_rvalid = 1'b0; #1;
    chk_out("wrap", 1'b1, ID, 32'hFFFF_FFFC, 32'h0);
    dec_ready = 1'b1; #1;
    chk_req("wrap", 1'b1, 32'h0);
    $display("step wrap: pc_if=%h pc_plus_4_if=%h next addr=%h", pc_if, pc_plus_4_if, imem_addr);

    // Reset while a request is outstanding; late response after release.
    cyc(); dec_ready = 1'b0; rst_n = 1'b0; #1;
    chk_out("rst_wait", 1'b0, NOP, 32'h0, 32'h4);
    chk_req("rst_wait", 1'b0, 32'h0);
    cyc(); rst_n = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hBEEF_0000; #1;
    chk_req("rst_release", 1'b1, 32'h0);
    cyc(); imem_rvalid = 1'b0; #1;
    chk_out("rst_late", 1'b0, NOP, 32'h0, 32'h4);
    cyc(); imem_rvalid = 1'b1; imem_rdata = IE; #1;
    cyc(); imem_rvalid = 1'b0; #1;
    chk_out("rst_fetch", 1'b1, IE, 32'h0, 32'h4);
    $display("step post-reset: instr=%h pc_if=%h", instruction, pc_if);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
